// File: rtl/router_pkg.sv
// Shared constants for the combone deflection router:
// flit field positions, direction codes and the port-pick helper.
package router_pkg;

    localparam int GOLDEN_BIT = 9;
    localparam int VALID_BIT  = 5;
    localparam int DY_MSB     = 4;
    localparam int DY_LSB     = 3;
    localparam int DX_MSB     = 2;
    localparam int DX_LSB     = 1;
    localparam int MESH_DIM   = 4;

    localparam logic [2:0] DIR_N = 3'd0;
    localparam logic [2:0] DIR_E = 3'd1;
    localparam logic [2:0] DIR_S = 3'd2;
    localparam logic [2:0] DIR_W = 3'd3;
    localparam logic [2:0] DIR_L = 3'd4;

    // Productive port if still free, else first free port in N,E,S,W order.
    function automatic logic [1:0] pick_port(
        input logic [3:0] free,
        input logic [2:0] dir
    );
        logic [1:0] p;
        logic       found;
        p     = 2'd0;
        found = 1'b0;
        if (dir != DIR_L && free[dir[1:0]]) begin
            p     = dir[1:0];
            found = 1'b1;
        end
        for (int k = 0; k < MESH_DIM; k++) begin
            if (!found && free[k]) begin
                p     = 2'(k);
                found = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/route_compute.sv
// XY dimension-order route computation for a single flit.
// X is resolved first, then Y, otherwise the flit is local.
module route_compute
    import router_pkg::*;
#(
    parameter int FLIT_W = 10
) (
    input  logic [FLIT_W-1:0] flit_i,
    input  logic [1:0]        x_i,
    input  logic [1:0]        y_i,
    output logic [2:0]        dir_o
);

    logic [1:0] dx;
    logic [1:0] dy;
    logic       unused_bits;

    assign dx = flit_i[DX_MSB:DX_LSB];
    assign dy = flit_i[DY_MSB:DY_LSB];
    assign unused_bits = ^{flit_i[FLIT_W-1:VALID_BIT], flit_i[0]};

    // Compare destination against this node, X before Y.
    always_comb begin
        dir_o = DIR_L;
        if (dx > x_i)      dir_o = DIR_E;
        else if (dx < x_i) dir_o = DIR_W;
        else if (dy > y_i) dir_o = DIR_N;
        else if (dy < y_i) dir_o = DIR_S;
    end

endmodule

// File: rtl/combone_router.sv
// Single-stage bufferless deflection router for one 4x4 mesh node.
// Ejects one local flit, injects if a slot is free, deflects the rest.
module combone_router
    import router_pkg::*;
#(
    parameter int X_COORD = 1,
    parameter int Y_COORD = 1,
    parameter int FLIT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] nin,
    input  logic [FLIT_W-1:0] sin,
    input  logic [FLIT_W-1:0] ein,
    input  logic [FLIT_W-1:0] win,
    input  logic [FLIT_W-1:0] lin,
    output logic [FLIT_W-1:0] nout,
    output logic [FLIT_W-1:0] sout,
    output logic [FLIT_W-1:0] eout,
    output logic [FLIT_W-1:0] wout,
    output logic [FLIT_W-1:0] lout,
    output logic              lin_ack
);

    localparam logic [1:0] XC = 2'(X_COORD);
    localparam logic [1:0] YC = 2'(Y_COORD);

    logic [FLIT_W-1:0] in_f   [MESH_DIM];
    logic [2:0]        dir_f  [MESH_DIM];
    logic [2:0]        dir_l;
    logic [FLIT_W-1:0] mesh_d [MESH_DIM];
    logic [FLIT_W-1:0] mesh_q [MESH_DIM];
    logic [FLIT_W-1:0] lout_d;
    logic [FLIT_W-1:0] lout_q;
    logic              ack_d;
    logic              ack_q;
    logic              ej_hit;
    logic [1:0]        ej_idx;
    logic [3:0]        keep;
    logic [2:0]        cnt;
    logic [3:0]        free;
    logic [1:0]        port;

    assign in_f[0] = nin;
    assign in_f[1] = ein;
    assign in_f[2] = sin;
    assign in_f[3] = win;

    for (genvar g = 0; g < MESH_DIM; g++) begin : g_rc
        route_compute #(.FLIT_W(FLIT_W)) u_rc (
            .flit_i (in_f[g]),
            .x_i    (XC),
            .y_i    (YC),
            .dir_o  (dir_f[g])
        );
    end

    route_compute #(.FLIT_W(FLIT_W)) u_rc_l (
        .flit_i (lin),
        .x_i    (XC),
        .y_i    (YC),
        .dir_o  (dir_l)
    );

    // Eject, count survivors, decide injection and allocate mesh ports.
    always_comb begin
        ej_hit = 1'b0;
        ej_idx = 2'd0;
        keep   = 4'd0;
        cnt    = 3'd0;
        free   = 4'hF;
        port   = 2'd0;
        for (int k = 0; k < MESH_DIM; k++) mesh_d[k] = '0;
        // Pass 0 services golden flits, pass 1 the rest.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < MESH_DIM; i++) begin
                if (!ej_hit && in_f[i][VALID_BIT] && dir_f[i] == DIR_L
                    && (in_f[i][GOLDEN_BIT] == (p == 0))) begin
                    ej_hit = 1'b1;
                    ej_idx = 2'(i);
                end
            end
        end
        for (int i = 0; i < MESH_DIM; i++) begin
            keep[i] = in_f[i][VALID_BIT] && !(ej_hit && ej_idx == 2'(i));
            cnt     = cnt + 3'(keep[i]);
        end
        ack_d = lin[VALID_BIT] && (cnt < 3'(MESH_DIM));
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < MESH_DIM; i++) begin
                if (keep[i] && (in_f[i][GOLDEN_BIT] == (p == 0))) begin
                    port         = pick_port(free, dir_f[i]);
                    mesh_d[port] = in_f[i];
                    free[port]   = 1'b0;
                end
            end
        end
        if (ack_d) begin
            port         = pick_port(free, dir_l);
            mesh_d[port] = lin;
            free[port]   = 1'b0;
        end
        lout_d = ej_hit ? in_f[ej_idx] : '0;
    end

    // Register every output; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MESH_DIM; k++) mesh_q[k] <= '0;
            lout_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            for (int k = 0; k < MESH_DIM; k++) mesh_q[k] <= mesh_d[k];
            lout_q <= lout_d;
            ack_q  <= ack_d;
        end
    end

    assign nout    = mesh_q[0];
    assign eout    = mesh_q[1];
    assign sout    = mesh_q[2];
    assign wout    = mesh_q[3];
    assign lout    = lout_q;
    assign lin_ack = ack_q;

endmodule

// File: tb/tb_combone_router.sv
// Bench for combone_router at node (1,1): directed flit patterns,
// expected outputs queued at drive time and compared one clock later.
module tb_combone_router;

    typedef struct packed {
        logic [9:0] n;
        logic [9:0] e;
        logic [9:0] s;
        logic [9:0] w;
        logic [9:0] l;
        logic       ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] nin = '0, sin = '0, ein = '0, win = '0, lin = '0;
    logic [9:0] nout, sout, eout, wout, lout;
    logic       lin_ack;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [9:0] F_E   = 10'b0000101100;
    localparam logic [9:0] F_EG  = 10'b1000101100;
    localparam logic [9:0] F_W   = 10'b0000101000;
    localparam logic [9:0] F_N   = 10'b0000110010;
    localparam logic [9:0] F_S   = 10'b0000100010;
    localparam logic [9:0] F_L   = 10'b0000101010;
    localparam logic [9:0] F_LG  = 10'b1000101010;
    localparam logic [9:0] F_INJ = 10'b0000101101;
    localparam logic [9:0] L1    = 10'b0001101010;
    localparam logic [9:0] L2    = 10'b0010101010;
    localparam logic [9:0] L3    = 10'b0011101010;
    localparam logic [9:0] L4    = 10'b0100101010;

    combone_router #(.X_COORD(1), .Y_COORD(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nin     (nin),
        .sin     (sin),
        .ein     (ein),
        .win     (win),
        .lin     (lin),
        .nout    (nout),
        .sout    (sout),
        .eout    (eout),
        .wout    (wout),
        .lout    (lout),
        .lin_ack (lin_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".n"}, nout, e.n);
        chk({tag, ".e"}, eout, e.e);
        chk({tag, ".s"}, sout, e.s);
        chk({tag, ".w"}, wout, e.w);
        chk({tag, ".l"}, lout, e.l);
        chk({tag, ".ack"}, {9'd0, lin_ack}, {9'd0, e.ack});
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after edge.
    task automatic step(input string tag,
                        input logic [9:0] n_i, e_i, s_i, w_i, l_i,
                        input exp_t e);
        exp_t got_e;
        nin = n_i; ein = e_i; sin = s_i; win = w_i; lin = l_i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".queue"}, 10'd0, 10'd1);
        end else begin
            got_e = sb.pop_front();
            chk_all(tag, got_e);
        end
    endtask

    initial begin
        exp_t z;
        z = '0;

        // Reset with random inputs: outputs zero immediately and while held.
        nin = 10'($urandom); ein = 10'($urandom); sin = 10'($urandom);
        win = 10'($urandom); lin = 10'($urandom) | 10'b0000100000;
        #1;
        chk_all("rst_now", z);
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_held", z);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("single", F_E, 0, 0, 0, 0,
             '{n: 0, e: F_E, s: 0, w: 0, l: 0, ack: 0});
        step("two_local", F_L, 0, F_L, 0, 0,
             '{n: F_L, e: 0, s: 0, w: 0, l: F_L, ack: 0});
        step("golden", F_E, 0, F_EG, 0, 0,
             '{n: F_E, e: F_EG, s: 0, w: 0, l: 0, ack: 0});
        step("full", F_E, F_W, F_N, F_S, F_INJ,
             '{n: F_N, e: F_E, s: F_S, w: F_W, l: 0, ack: 0});
        step("idle", 0, 0, 0, 0, 0, z);
        step("invalid", 10'b1111011111, 10'b0101011110, 10'b1001011011,
             10'b0111010101, 10'b1111011111, z);
        step("gold_eject", F_L, 0, 0, F_LG, 0,
             '{n: F_L, e: 0, s: 0, w: 0, l: F_LG, ack: 0});
        step("inject_alone", 0, 0, 0, 0, F_INJ,
             '{n: 0, e: F_INJ, s: 0, w: 0, l: 0, ack: 1});
        step("all_local", L1, L2, L3, L4, F_INJ,
             '{n: L2, e: L3, s: L4, w: F_INJ, l: L1, ack: 1});
        step("eject_frees", F_L, F_W, F_N, F_S, F_INJ,
             '{n: F_N, e: F_INJ, s: F_S, w: F_W, l: F_L, ack: 1});

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", z);
        @(posedge clk);
        #1;
        chk_all("rst_async_hold", z);
        rst_n = 1'b1;
        step("after_rst", 0, F_E, 0, 0, 0,
             '{n: 0, e: F_E, s: 0, w: 0, l: 0, ack: 0});

        chk("sb_empty", 10'(sb.size()), 10'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/combone_router.md
Name: combone_router

Overview:
- Single-stage bufferless deflection router (CHIPPER style) for one node of a 4x4 2D mesh.
- Each cycle it takes one 10-bit flit from each of four mesh links (N, E, S, W) plus one local injection flit.
- It ejects at most one flit to the local port, injects the local flit if a slot is free, and routes or deflects every remaining flit so no flit is dropped.
- Outputs are registered, with one-cycle latency.

Parameters:
- X_COORD, 1, this router's x coordinate (0..3).
- Y_COORD, 1, this router's y coordinate (0..3).
- FLIT_W, 10, flit width (fixed at 10; not intended to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- nin  in  10  north link input flit.
- sin  in  10  south link input flit.
- ein  in  10  east link input flit.
- win  in  10  west link input flit.
- lin  in  10  local injection flit.
- nout  out  10  north link output flit.
- sout  out  10  south link output flit.
- eout  out  10  east link output flit.
- wout  out  10  west link output flit.
- lout  out  10  local ejection flit.
- lin_ack  out  1  registered; 1 = lin was accepted in the previous cycle.

Behaviour:
- Flit format:
  - [9] golden (priority)
  - [8:6] payload tag
  - [5] valid
  - [4:3] dest_y
  - [2:1] dest_x
  - [0] payload bit
- A flit with [5]=0 is empty. Empty outputs drive all-zero.
- Reset (async, rst_n=0): all outputs including lin_ack go to 0 immediately and hold until the first rising clk after release.
- Productive direction (XY routing):
  - dest_x > X_COORD → E; dest_x < X_COORD → W.
  - Otherwise dest_y > Y_COORD → N; dest_y < Y_COORD → S.
  - Otherwise local.
- Ejection:
  - Among valid network inputs whose direction is local, exactly one is sent to lout.
  - Selection: golden first, then fixed order N, E, S, W.
  - Any other local-bound flits are deflected onto mesh ports.
- Injection:
  - lin is accepted when lin[5]=1 and fewer than 4 network flits remain after ejection.
  - If accepted, lin_ack=1 next cycle; otherwise lin is dropped and lin_ack=0. Resending is the source's duty.
- Port allocation (combinational, same cycle):
  - Service order: golden flits first, then N, E, S, W inputs, then injected lin.
  - Each flit takes its productive mesh port if still free.
  - Otherwise it is deflected to the first free port in order N, E, S, W.
  - The flit count never exceeds 4, so every flit gets a port.
- All five outputs and lin_ack are registered on the rising clk. Latency is exactly 1 cycle. There is no handshake on the mesh links.
- The golden bit is passed through unchanged. Flit contents are never modified.
- Simultaneous golden flits are resolved by the N, E, S, W order.

Decomposition:
- Shared package router_pkg holds:
  - flit bit-position constants (GOLDEN_BIT, VALID_BIT, DY_MSB/LSB, DX_MSB/LSB)
  - direction encoding constants (DIR_N, DIR_E, DIR_S, DIR_W, DIR_L)
  - mesh size constant (4)
- One sub-module, route_compute: flit plus coordinates in, productive direction out. It is instantiated 5 times.
- Ejection, injection and allocation logic and output registers live in combone_router.

Test Plan (X_COORD=1, Y_COORD=1; each check is one clk after the stimulus):
- Reset:
  - Stimulus: assert rst_n=0 with random inputs.
  - Required: all outputs and lin_ack are 0 immediately, and stay 0 on clocks while held.
- Single flit:
  - Stimulus: nin=10'b0000101100 (to x2, y1), all other inputs 0.
  - Required: eout=10'b0000101100; nout, sout, wout, lout = 0.
- Two local-bound flits:
  - Stimulus: nin=sin=10'b0000101010 (local), others 0.
  - Required: lout=10'b0000101010 (from nin); nout=10'b0000101010 (sin deflected to first free port).
- Golden priority:
  - Stimulus: nin=10'b0000101100 and sin=10'b1000101100 (golden), both to E.
  - Required: eout=10'b1000101100; nout=10'b0000101100 (deflected).
- Full links:
  - Stimulus: all four inputs valid and non-local (E, W, N and S bound), lin=10'b0000101101.
  - Required: lin_ack=0; all four mesh outputs valid; lout=0.
- Ejection frees a slot:
  - Stimulus: nin local, ein/sin/win valid mesh-bound, lin=10'b0000101101.
  - Required: lout=nin; lin_ack=1; lin appears on a mesh output.
  - Then pulse rst_n low mid-stream: outputs clear asynchronously.
